// File: rtl/wakeup_frame_tx_if.sv
// wakeup_frame_tx_if
//   Bundles the host byte-source handshake and the line-driver outputs of
//   wakeup_frame_tx. Clock and reset are not part of the bundle.
//   master : host side (drives start/byte_in/byte_valid, observes the rest)
//   slave  : wakeup_frame_tx side
// Signals
//   start       host -> tx  one-cycle frame request
//   byte_in     host -> tx  payload byte
//   byte_valid  host -> tx  byte_in valid
//   byte_ready  tx -> host  byte_in accepted this cycle
//   wake_up     tx -> line  wake-up pulse
//   tx_data     tx -> line  serial data
//   tx_clk      tx -> line  forwarded bit clock (receiver samples on rise)
//   busy        tx -> host  frame in progress
//   done        tx -> host  one-cycle end-of-frame pulse
//   underrun    tx -> host  sticky: payload byte needed but not valid
interface wakeup_frame_tx_if;
    logic       start;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;
    logic       wake_up;
    logic       tx_data;
    logic       tx_clk;
    logic       busy;
    logic       done;
    logic       underrun;

    modport master (
        output start, byte_in, byte_valid,
        input  byte_ready, wake_up, tx_data, tx_clk, busy, done, underrun
    );

    modport slave (
        input  start, byte_in, byte_valid,
        output byte_ready, wake_up, tx_data, tx_clk, busy, done, underrun
    );
endinterface

// File: rtl/wakeup_frame_tx.sv
// wakeup_frame_tx
//   Transmit side of the wake-up/sync link. On start: wake-up pulse for
//   WAKE_TICKS cycles, guard interval up to GUARD_TICKS, then PREAMBLE_BITS
//   zero bits followed by PAYLOAD_BYTES bytes, MSB first, one bit per
//   DATARATE_DIV cycles with a forwarded bit clock (low half, then high half).
//   Optional macro WAKEUP_TX_CRC_EN appends a CRC-8 (poly 0x07, init 0x00)
//   byte over the payload bytes actually sent.
// Ports
//   clki   system clock
//   rst_n  asynchronous active-low reset
//   bus    wakeup_frame_tx_if.slave (handshake and line-driver signals)
module wakeup_frame_tx #(
    parameter int unsigned DATARATE_DIV  = 100,
    parameter int unsigned WAKE_TICKS    = 1000,
    parameter int unsigned GUARD_TICKS   = 25342,
    parameter int unsigned PREAMBLE_BITS = 432,
    parameter int unsigned PAYLOAD_BYTES = 71
) (
    input  logic               clki,
    input  logic               rst_n,
    wakeup_frame_tx_if.slave   bus
);

    localparam int unsigned PH_W = $clog2(DATARATE_DIV);
    localparam int unsigned PB_W = $clog2(PREAMBLE_BITS + 1);
    localparam int unsigned BY_W = $clog2(PAYLOAD_BYTES + 1);

    localparam logic [PH_W-1:0] PH_LAST    = PH_W'(DATARATE_DIV - 1);
    localparam logic [PH_W-1:0] PH_HALF    = PH_W'(DATARATE_DIV / 2);
    localparam logic [PH_W-1:0] PH_ONE     = PH_W'(1);
    localparam logic [19:0]     WAKE_LAST  = 20'(WAKE_TICKS - 1);
    localparam logic [19:0]     GUARD_LAST = 20'(GUARD_TICKS - 1);
    localparam logic [PB_W-1:0] PB_LAST    = PB_W'(PREAMBLE_BITS - 1);
    localparam logic [PB_W-1:0] PB_ONE     = PB_W'(1);
    localparam logic [BY_W-1:0] BY_LAST    = BY_W'(PAYLOAD_BYTES - 1);
    localparam logic [BY_W-1:0] BY_ONE     = BY_W'(1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAKE  = 3'd1;
    localparam logic [2:0] S_GUARD = 3'd2;
    localparam logic [2:0] S_PRE   = 3'd3;
    localparam logic [2:0] S_PAY   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd6;
`ifdef WAKEUP_TX_CRC_EN
    localparam logic [2:0] S_CRC   = 3'd5;
    localparam logic [2:0] S_AFTER_PAY = S_CRC;
`else
    localparam logic [2:0] S_AFTER_PAY = S_DONE;
`endif

    logic [2:0]      state_q, state_d;
    logic [19:0]     tick_q, tick_d;
    logic [PH_W-1:0] ph_q, ph_d;
    logic [PB_W-1:0] pre_q, pre_d;
    logic [2:0]      bitn_q, bitn_d;
    logic [BY_W-1:0] byte_q, byte_d;
    logic [7:0]      sh_q, sh_d;
    logic            tx_data_q, tx_data_d;
    logic            tx_clk_q, tx_clk_d;
    logic            wake_up_q, wake_up_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            byte_ready_q, byte_ready_d;
    logic            underrun_q, underrun_d;
    logic [7:0]      load_byte;
    logic            bit_end;
`ifdef WAKEUP_TX_CRC_EN
    logic [7:0]      crc_q, crc_d;

    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction
`endif

    assign bit_end = (ph_q == PH_LAST);

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        ph_d       = ph_q;
        pre_d      = pre_q;
        bitn_d     = bitn_q;
        byte_d     = byte_q;
        sh_d       = sh_q;
        tx_data_d  = tx_data_q;
        underrun_d = underrun_q;
`ifdef WAKEUP_TX_CRC_EN
        crc_d      = crc_q;
`endif
        load_byte  = bus.byte_valid ? bus.byte_in : 8'h00;
`ifdef WAKEUP_TX_CRC_EN
        if (state_q == S_CRC) load_byte = crc_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d    = S_WAKE;
                    tick_d     = '0;
                    ph_d       = '0;
                    pre_d      = '0;
                    bitn_d     = '0;
                    byte_d     = '0;
                    tx_data_d  = 1'b0;
                    underrun_d = 1'b0;
`ifdef WAKEUP_TX_CRC_EN
                    crc_d      = '0;
`endif
                end
            end
            S_WAKE: begin
                tick_d = tick_q + 20'd1;
                if (tick_q == WAKE_LAST) state_d = S_GUARD;
            end
            S_GUARD: begin
                // tick stops advancing once the preamble begins
                tick_d = tick_q + 20'd1;
                if (tick_q == GUARD_LAST) begin
                    state_d = S_PRE;
                    ph_d    = '0;
                    pre_d   = '0;
                end
            end
            S_PRE: begin
                ph_d = bit_end ? '0 : ph_q + PH_ONE;
                if (bit_end) begin
                    pre_d = pre_q + PB_ONE;
                    if (pre_q == PB_LAST) begin
                        state_d = S_PAY;
                        bitn_d  = '0;
                        byte_d  = '0;
                    end
                end
            end
            S_PAY
`ifdef WAKEUP_TX_CRC_EN
            , S_CRC
`endif
            : begin
                ph_d = bit_end ? '0 : ph_q + PH_ONE;
                // The byte is taken in the byte_ready cycle, so its MSB reaches
                // tx_data one cycle into the period, still ahead of the tx_clk rise.
                if (ph_q == '0) begin
                    if (bitn_q == 3'd0) begin
                        tx_data_d = load_byte[7];
                        sh_d      = {load_byte[6:0], 1'b0};
                        if (state_q == S_PAY) begin
                            if (!bus.byte_valid) underrun_d = 1'b1;
`ifdef WAKEUP_TX_CRC_EN
                            crc_d = crc8_byte(crc_q, load_byte);
`endif
                        end
                    end else begin
                        tx_data_d = sh_q[7];
                        sh_d      = {sh_q[6:0], 1'b0};
                    end
                end
                if (bit_end) begin
                    bitn_d = bitn_q + 3'd1;
                    if (bitn_q == 3'd7) begin
                        if (state_q == S_PAY) begin
                            byte_d = byte_q + BY_ONE;
                            if (byte_q == BY_LAST) state_d = S_AFTER_PAY;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_DONE) tx_data_d = 1'b0;

        // Outputs are registered from the next state so they align with it.
        wake_up_d    = (state_d == S_WAKE);
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
        byte_ready_d = (state_d == S_PAY) && (ph_d == '0) && (bitn_d == 3'd0);
        tx_clk_d     = ((state_d == S_PRE) || (state_d == S_PAY)
`ifdef WAKEUP_TX_CRC_EN
                        || (state_d == S_CRC)
`endif
                       ) && (ph_d >= PH_HALF);
    end

    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            tick_q       <= '0;
            ph_q         <= '0;
            pre_q        <= '0;
            bitn_q       <= '0;
            byte_q       <= '0;
            sh_q         <= '0;
            tx_data_q    <= 1'b0;
            tx_clk_q     <= 1'b0;
            wake_up_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            byte_ready_q <= 1'b0;
            underrun_q   <= 1'b0;
`ifdef WAKEUP_TX_CRC_EN
            crc_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            ph_q         <= ph_d;
            pre_q        <= pre_d;
            bitn_q       <= bitn_d;
            byte_q       <= byte_d;
            sh_q         <= sh_d;
            tx_data_q    <= tx_data_d;
            tx_clk_q     <= tx_clk_d;
            wake_up_q    <= wake_up_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            byte_ready_q <= byte_ready_d;
            underrun_q   <= underrun_d;
`ifdef WAKEUP_TX_CRC_EN
            crc_q        <= crc_d;
`endif
        end
    end

    assign bus.wake_up    = wake_up_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.tx_clk     = tx_clk_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.byte_ready = byte_ready_q;
    assign bus.underrun   = underrun_q;

endmodule

// File: tb/tb_wakeup_frame_tx.sv
// tb_wakeup_frame_tx
//   Self-checking bench for wakeup_frame_tx with small parameters. A monitor
//   captures tx_data at each tx_clk rise and records pulse counts and times;
//   a reference model builds the expected bit stream from the frame rules.
//   Honours WAKEUP_TX_CRC_EN to expect the trailing CRC byte.
module tb_wakeup_frame_tx;
    localparam int DIV    = 4;
    localparam int WAKE   = 3;
    localparam int GUARD  = 10;
    localparam int PRE    = 4;
    localparam int NBYTES = 2;
`ifdef WAKEUP_TX_CRC_EN
    localparam int CRC_BYTES = 1;
`else
    localparam int CRC_BYTES = 0;
`endif
    localparam int NBITS = PRE + 8 * (NBYTES + CRC_BYTES);

    logic clki  = 1'b0;
    logic rst_n = 1'b0;
    always #5 clki = ~clki;

    wakeup_frame_tx_if bus ();

    wakeup_frame_tx #(
        .DATARATE_DIV (DIV),
        .WAKE_TICKS   (WAKE),
        .GUARD_TICKS  (GUARD),
        .PREAMBLE_BITS(PRE),
        .PAYLOAD_BYTES(NBYTES)
    ) dut (
        .clki (clki),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clki) cyc <= cyc + 1;

    // monitor state
    int   wake_cnt, wake_first, rise_first, ready_cnt, done_cnt, done_cyc;
    logic got_bits[$];
    logic prev_clk = 1'b0;
    int   clr_tok = 0, clr_seen = 0;

    // byte source pattern
    logic [7:0] pat_b[2] = '{8'h00, 8'h00};
    logic       pat_v[2] = '{1'b0, 1'b0};
    int         idx = 0;
    logic       ready_prev = 1'b0;

    // model outputs
    logic exp_bits[$];
    logic exp_underrun;
    logic first_busy, first_und;

    always @(negedge clki) begin
        if (clr_tok != clr_seen) begin
            clr_seen   = clr_tok;
            wake_cnt   = 0;
            wake_first = -1;
            rise_first = -1;
            ready_cnt  = 0;
            done_cnt   = 0;
            done_cyc   = -1;
            got_bits.delete();
        end
        if (bus.wake_up) begin
            wake_cnt++;
            if (wake_first < 0) wake_first = cyc;
        end
        if (bus.tx_clk && !prev_clk) begin
            got_bits.push_back(bus.tx_data);
            if (rise_first < 0) rise_first = cyc;
        end
        prev_clk = bus.tx_clk;
        if (bus.byte_ready) ready_cnt++;
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (!bus.busy) idx = 0;
        else if (ready_prev) idx++;
        ready_prev     = bus.byte_ready;
        bus.byte_in    = (idx < 2) ? pat_b[idx] : 8'h00;
        bus.byte_valid = (idx < 2) ? pat_v[idx] : 1'b0;
    end

    // CRC as remainder of message * x^8 divided by x^8 + x^2 + x + 1
    function automatic logic [7:0] crc_ref(input logic [7:0] a, input logic [7:0] b);
        logic [23:0] r;
        r = {a, b, 8'h00};
        for (int i = 23; i >= 8; i--) begin
            if (r[i]) r = r ^ (24'h107 << (i - 8));
        end
        return r[7:0];
    endfunction

    task automatic build_model(input logic [7:0] b0, input logic [7:0] b1,
                               input logic v0, input logic v1);
        logic [7:0] s0, s1, c;
        exp_bits.delete();
        for (int i = 0; i < PRE; i++) exp_bits.push_back(1'b0);
        s0 = v0 ? b0 : 8'h00;
        s1 = v1 ? b1 : 8'h00;
        for (int i = 7; i >= 0; i--) exp_bits.push_back(s0[i]);
        for (int i = 7; i >= 0; i--) exp_bits.push_back(s1[i]);
        if (CRC_BYTES != 0) begin
            c = crc_ref(s0, s1);
            for (int i = 7; i >= 0; i--) exp_bits.push_back(c[i]);
        end
        exp_underrun = !(v0 && v1);
    endtask

    task automatic start_frame(input logic [7:0] b0, input logic [7:0] b1,
                               input logic v0, input logic v1, output int n0);
        pat_b[0] = b0; pat_b[1] = b1;
        pat_v[0] = v0; pat_v[1] = v1;
        build_model(b0, b1, v0, v1);
        clr_tok++;
        @(negedge clki);
        @(negedge clki);
        bus.start = 1'b1;
        n0 = cyc;
        @(negedge clki);
        bus.start  = 1'b0;
        first_busy = bus.busy;
        first_und  = bus.underrun;
    endtask

    task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1,
                             input logic v0, input logic v1, input bit mid_start,
                             output int n0, output bit timed_out);
        int t;
        start_frame(b0, b1, v0, v1, n0);
        if (mid_start) begin
            t = 0;
            while (ready_cnt == 0 && t < 400) begin @(negedge clki); t++; end
            @(negedge clki);
            bus.start = 1'b1;
            @(negedge clki);
            bus.start = 1'b0;
        end
        t = 0;
        while (done_cnt == 0 && t < 600) begin @(posedge clki); t++; end
        timed_out = (done_cnt == 0);
        repeat (3) @(negedge clki);
    endtask

    function automatic int bit_errors();
        int e;
        e = 0;
        for (int i = 0; i < exp_bits.size(); i++) begin
            if (i >= got_bits.size()) e++;
            else if (got_bits[i] !== exp_bits[i]) e++;
        end
        return e;
    endfunction

    task automatic test_reset();
        logic [6:0] outs;
        rst_n = 1'b0;
        repeat (3) @(negedge clki);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clki);
            outs = {bus.wake_up, bus.tx_data, bus.tx_clk, bus.busy,
                    bus.done, bus.byte_ready, bus.underrun};
            n_cmp++;
            if (outs !== 7'b0) begin
                n_bad++;
                $display("FAIL reset_idle cycle %0d: outputs=%b expected=0000000", i, outs);
            end
        end
    endtask

    task automatic test_payload();
        logic [7:0] b0, b1;
        logic v0, v1;
        int n0, e;
        bit to;
        for (int k = 0; k < 7; k++) begin
            case (k)
                0: begin b0 = 8'hA5; b1 = 8'h3C; v0 = 1'b1; v1 = 1'b1; end
                1: begin b0 = 8'hA5; b1 = 8'h3C; v0 = 1'b1; v1 = 1'b0; end
                2: begin b0 = 8'h01; b1 = 8'h02; v0 = 1'b1; v1 = 1'b1; end
                default: begin
                    b0 = 8'($urandom); b1 = 8'($urandom);
                    v0 = ($urandom_range(0, 3) != 0);
                    v1 = ($urandom_range(0, 3) != 0);
                end
            endcase
            run_frame(b0, b1, v0, v1, 1'b0, n0, to);
            n_cmp++;
            if (to) begin n_bad++; $display("FAIL frame%0d_timeout: done not seen", k); end
            n_cmp++;
            if (first_busy !== 1'b1 || first_und !== 1'b0) begin
                n_bad++;
                $display("FAIL frame%0d_start: busy=%b underrun=%b expected busy=1 underrun=0",
                         k, first_busy, first_und);
            end
            n_cmp++;
            if (got_bits.size() != NBITS) begin
                n_bad++;
                $display("FAIL frame%0d_nbits: got %0d expected %0d", k, got_bits.size(), NBITS);
            end
            e = bit_errors();
            n_cmp++;
            if (e != 0) begin
                n_bad++;
                $display("FAIL frame%0d_bits: %0d wrong bits expected 0 (b0=%h b1=%h v=%b%b)",
                         k, e, b0, b1, v0, v1);
            end
            n_cmp++;
            if (wake_cnt != WAKE || wake_first != n0 + 1) begin
                n_bad++;
                $display("FAIL frame%0d_wake: len=%0d at %0d expected len=%0d at %0d",
                         k, wake_cnt, wake_first, WAKE, n0 + 1);
            end
            n_cmp++;
            if (rise_first != n0 + 1 + GUARD + DIV / 2) begin
                n_bad++;
                $display("FAIL frame%0d_first_rise: cycle %0d expected %0d",
                         k, rise_first, n0 + 1 + GUARD + DIV / 2);
            end
            n_cmp++;
            if (ready_cnt != NBYTES) begin
                n_bad++;
                $display("FAIL frame%0d_ready_pulses: got %0d expected %0d", k, ready_cnt, NBYTES);
            end
            n_cmp++;
            if (done_cnt != 1 || done_cyc != n0 + 1 + GUARD + NBITS * DIV) begin
                n_bad++;
                $display("FAIL frame%0d_done: count=%0d at %0d expected 1 at %0d",
                         k, done_cnt, done_cyc, n0 + 1 + GUARD + NBITS * DIV);
            end
            n_cmp++;
            if (bus.busy !== 1'b0 || bus.underrun !== exp_underrun) begin
                n_bad++;
                $display("FAIL frame%0d_after: busy=%b underrun=%b expected busy=0 underrun=%b",
                         k, bus.busy, bus.underrun, exp_underrun);
            end
        end
    endtask

    task automatic test_start_mid_payload();
        int n0;
        bit to;
        run_frame(8'($urandom), 8'($urandom), 1'b1, 1'b1, 1'b1, n0, to);
        n_cmp++;
        if (to || bit_errors() != 0 || got_bits.size() != NBITS) begin
            n_bad++;
            $display("FAIL mid_start_bits: timeout=%0d errors=%0d nbits=%0d expected 0/0/%0d",
                     to, bit_errors(), got_bits.size(), NBITS);
        end
        n_cmp++;
        if (done_cnt != 1 || done_cyc != n0 + 1 + GUARD + NBITS * DIV || wake_cnt != WAKE) begin
            n_bad++;
            $display("FAIL mid_start_timing: done=%0d at %0d wake=%0d expected 1 at %0d wake=%0d",
                     done_cnt, done_cyc, wake_cnt, n0 + 1 + GUARD + NBITS * DIV, WAKE);
        end
    endtask

    task automatic test_back_to_back();
        int n0, td, t, wk;
        start_frame(8'h5A, 8'hC3, 1'b1, 1'b1, n0);
        td = n0 + 1 + GUARD + NBITS * DIV;
        t  = 0;
        while (cyc < td && t < 1000) begin @(negedge clki); t++; end
        n_cmp++;
        if (bus.done !== 1'b1) begin
            n_bad++;
            $display("FAIL done_cycle: done=%b at cycle %0d expected 1", bus.done, td);
        end
        bus.start = 1'b1;
        @(negedge clki);
        bus.start = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.wake_up !== 1'b0) begin
            n_bad++;
            $display("FAIL start_on_done: busy=%b wake_up=%b expected 0 0", bus.busy, bus.wake_up);
        end
        wk = 0;
        repeat (6) begin @(negedge clki); if (bus.wake_up || bus.busy) wk++; end
        n_cmp++;
        if (wk != 0) begin
            n_bad++;
            $display("FAIL start_on_done_idle: %0d active cycles expected 0", wk);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n0, t;
        bit to;
        logic [6:0] outs;
        start_frame(8'hFF, 8'hFF, 1'b0, 1'b1, n0);
        t = 0;
        while (ready_cnt == 0 && t < 400) begin @(negedge clki); t++; end
        repeat (3) @(negedge clki);
        n_cmp++;
        if (bus.underrun !== 1'b1 || bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL underrun_midframe: underrun=%b busy=%b expected 1 1", bus.underrun, bus.busy);
        end
        rst_n = 1'b0;
        #1;
        outs = {bus.wake_up, bus.tx_data, bus.tx_clk, bus.busy,
                bus.done, bus.byte_ready, bus.underrun};
        n_cmp++;
        if (outs !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_midframe: outputs=%b expected 0000000", outs);
        end
        @(negedge clki);
        rst_n = 1'b1;
        repeat (4) @(negedge clki);
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_no_resume: busy=%b expected 0", bus.busy);
        end
        run_frame(8'h96, 8'h0F, 1'b1, 1'b1, 1'b0, n0, to);
        n_cmp++;
        if (to || bit_errors() != 0 || done_cyc != n0 + 1 + GUARD + NBITS * DIV) begin
            n_bad++;
            $display("FAIL reset_recovery: timeout=%0d errors=%0d done at %0d expected 0/0/%0d",
                     to, bit_errors(), done_cyc, n0 + 1 + GUARD + NBITS * DIV);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        test_reset();
        test_payload();
        test_start_mid_payload();
        test_back_to_back();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
